tff_mod_counter: RTL and testbench

//   Parametrised modulo-N up/down counter built from toggle flip-flop cells.

---
 rtl/tff_mod_counter_pkg.sv | 18 +
 rtl/tff_mod_counter_if.sv | 29 ++
 rtl/tff_mod_counter_cell.sv | 27 ++
 rtl/tff_mod_counter.sv | 89 ++++++++
 tb/tb_tff_mod_counter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/tff_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tff_mod_counter_pkg
//  Description : Legal parameter ranges and range-check helper for the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package tff_mod_counter_pkg;

    localparam int WIDTH_MIN   = 1;
    localparam int WIDTH_MAX   = 16;
    localparam int MODULUS_MIN = 2;

    function automatic bit modulus_legal(input int width, input int modulus);
        return (modulus >= MODULUS_MIN) && (modulus <= (1 << width));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_mod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tff_mod_counter_if
//  Description : Control/status bundle of one counter digit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tff_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;

    modport master (
        output clear, load, load_value, enable, up,
        input  count, tc, wrapped
    );

    modport slave (
        input  clear, load, load_value, enable, up,
        output count, tc, wrapped
    );
endinterface
`default_nettype wire

// File: rtl/tff_mod_counter_cell.sv
`default_nettype none
// ============================================================================
//  Module      : tff_cell
//  Description : One-bit toggle flip-flop with synchronous load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  wire  clock,
    input  wire  resetn,
    input  wire  ld,
    input  wire  d,
    input  wire  t,
    output logic q
);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tff_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tff_mod_counter
//  Description : Modulo-N up/down counter built from toggle cells, cascadable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  wire              clock,
    input  wire              resetn,
    tff_mod_counter_if.slave bus
);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $error("tff_mod_counter: WIDTH %0d outside 1..16", WIDTH);
    end
    if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("tff_mod_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] ld_value;
    logic             ld;
    logic             wrap_d;
    logic             wrapped_q;

    // Counting path only; clear/load override it through the cells' ld input.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.enable) begin
            if (bus.up) begin
                if (count_q != MAX_VAL) begin
                    count_d = count_q + WIDTH'(1);
                end else if (SATURATE == 0) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else if (SATURATE == 0) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    assign t_vec    = count_q ^ count_d;
    assign ld       = bus.clear | bus.load;
    assign ld_value = bus.clear ? '0 :
                      (bus.load_value > MAX_VAL) ? MAX_VAL : bus.load_value;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clock  (clock),
            .resetn (resetn),
            .ld     (ld),
            .d      (ld_value[i]),
            .t      (t_vec[i]),
            .q      (count_q[i])
        );
    end

    always_ff @(posedge clock) begin
        if (!resetn || ld) begin
            wrapped_q <= 1'b0;
        end else begin
            wrapped_q <= wrap_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.wrapped = wrapped_q;
    assign bus.tc      = bus.enable & ((bus.up & (count_q == MAX_VAL)) |
                                       (~bus.up & (count_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_tff_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tff_mod_counter
//  Description : Self-checking bench: wrap and saturate digits, two cascades.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_mod_counter;

    logic clock;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    int ma_c, ms_c;
    bit ma_w, ms_w;

    tff_mod_counter_if #(.WIDTH(4)) ia ();
    tff_mod_counter_if #(.WIDTH(4)) isat ();
    tff_mod_counter_if #(.WIDTH(4)) ic_lo ();
    tff_mod_counter_if #(.WIDTH(4)) ic_hi ();
    tff_mod_counter_if #(.WIDTH(3)) io_lo ();
    tff_mod_counter_if #(.WIDTH(3)) io_hi ();

    assign ic_hi.enable = ic_lo.tc;
    assign io_hi.enable = io_lo.tc;

    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a    (.clock(clock), .resetn(resetn), .bus(ia));
    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s    (.clock(clock), .resetn(resetn), .bus(isat));
    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c_lo (.clock(clock), .resetn(resetn), .bus(ic_lo));
    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c_hi (.clock(clock), .resetn(resetn), .bus(ic_hi));
    tff_mod_counter #(.WIDTH(3), .MODULUS(8),  .SATURATE(0)) u_o_lo (.clock(clock), .resetn(resetn), .bus(io_lo));
    tff_mod_counter #(.WIDTH(3), .MODULUS(8),  .SATURATE(0)) u_o_hi (.clock(clock), .resetn(resetn), .bus(io_hi));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_tc(input int c, input int m, input bit en, input bit up);
        return (en && ((up && c == m - 1) || (!up && c == 0))) ? 1 : 0;
    endfunction

    // Behavioural digit: unbounded step, then fold back into 0..m-1.
    task automatic ref_step(input int m, input bit sat, input bit rst, input bit clr,
                            input bit ld, input int lv, input bit en, input bit up,
                            inout int c, inout bit w);
        int raw;
        if (!rst || clr) begin
            c = 0; w = 0;
        end else if (ld) begin
            c = (lv > m - 1) ? m - 1 : lv; w = 0;
        end else if (en) begin
            raw = up ? c + 1 : c - 1;
            if (sat) begin
                c = (raw < 0) ? 0 : (raw > m - 1) ? m - 1 : raw;
                w = 0;
            end else begin
                w = (raw < 0) || (raw >= m);
                c = (raw + m) % m;
            end
        end else begin
            w = 0;
        end
    endtask

    task automatic step(input bit rst, input bit clr, input bit ld, input logic [3:0] lv,
                        input bit en, input bit up);
        resetn = rst;
        ia.clear = clr;   ia.load = ld;   ia.load_value = lv;   ia.enable = en;   ia.up = up;
        isat.clear = clr; isat.load = ld; isat.load_value = lv; isat.enable = en; isat.up = up;
        #1;
        chk("wrap_tc", ia.tc, exp_tc(ma_c, 10, en, up));
        chk("sat_tc", isat.tc, exp_tc(ms_c, 10, en, up));
        @(posedge clock);
        #1;
        ref_step(10, 1'b0, rst, clr, ld, int'(lv), en, up, ma_c, ma_w);
        ref_step(10, 1'b1, rst, clr, ld, int'(lv), en, up, ms_c, ms_w);
        chk("wrap_count", ia.count, ma_c);
        chk("wrap_wrapped", ia.wrapped, int'(ma_w));
        chk("sat_count", isat.count, ms_c);
        chk("sat_wrapped", isat.wrapped, int'(ms_w));
    endtask

    initial begin
        ma_c = 0; ms_c = 0; ma_w = 0; ms_w = 0;
        resetn = 1'b0;
        ic_lo.clear = 0; ic_lo.load = 0; ic_lo.load_value = '0; ic_lo.enable = 0; ic_lo.up = 1;
        ic_hi.clear = 0; ic_hi.load = 0; ic_hi.load_value = '0; ic_hi.up = 1;
        io_lo.clear = 0; io_lo.load = 0; io_lo.load_value = '0; io_lo.enable = 0; io_lo.up = 1;
        io_hi.clear = 0; io_hi.load = 0; io_hi.load_value = '0; io_hi.up = 1;

        // Reset, then count up through one wrap
        step(0, 0, 0, 4'd0, 1, 1);
        chk("reset_count", ia.count, 0);
        chk("reset_wrapped", ia.wrapped, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 4'd0, 1, 1);
        chk("up12_count", ia.count, 2);

        // Down from 0 wraps to 9
        step(1, 1, 0, 4'd0, 0, 0);
        step(1, 0, 0, 4'd0, 1, 0);
        chk("down_wrap_count", ia.count, 9);
        chk("down_wrap_pulse", ia.wrapped, 1);

        // Saturation at top, then count down
        step(1, 0, 1, 4'd9, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd0, 1, 1);
        chk("sat_hold", isat.count, 9);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd0, 1, 0);
        chk("sat_down", isat.count, 6);

        // Load clamp and clear-over-load
        step(1, 0, 1, 4'd13, 1, 1);
        chk("load_clamp", ia.count, 9);
        step(1, 1, 1, 4'd7, 1, 1);
        chk("clear_over_load", ia.count, 0);

        // Reset mid-count
        step(1, 0, 1, 4'd5, 0, 1);
        step(0, 0, 0, 4'd0, 1, 1);
        chk("midreset_count", ia.count, 0);
        step(1, 0, 0, 4'd0, 1, 1);
        chk("resume_count", ia.count, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        // Cascades: decimal 00..99 and octal 00..77
        resetn = 1'b0;
        ia.enable = 0; isat.enable = 0;
        ic_lo.enable = 1; io_lo.enable = 1;
        @(posedge clock); #1;
        resetn = 1'b1;
        chk("casc_reset_lo", ic_lo.count, 0);
        chk("casc_reset_hi", ic_hi.count, 0);
        for (int n = 1; n <= 100; n++) begin
            chk("casc_hi_en", ic_hi.enable, ((n - 1) % 10 == 9) ? 1 : 0);
            @(posedge clock); #1;
            chk("casc_lo", ic_lo.count, n % 10);
            chk("casc_hi", ic_hi.count, (n / 10) % 10);
            chk("casc_lo_wrap", ic_lo.wrapped, (n % 10 == 0) ? 1 : 0);
            chk("oct_lo", io_lo.count, n % 8);
            chk("oct_hi", io_hi.count, (n / 8) % 8);
            chk("oct_lo_wrap", io_lo.wrapped, (n % 8 == 0) ? 1 : 0);
            if (n == 45) chk("casc_45", {ic_hi.count, ic_lo.count}, 'h45);
        end
        chk("casc_100", {ic_hi.count, ic_lo.count}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
